vec_dot_accum: RTL
==================

VEC_DOT_ACCUM -- requirements
Module: vec_dot_accum

Interface
REQ-001 SHALL have parameter LANES, default 4: number of lanes per beat, legal values 1..16.
REQ-002 SHALL have parameter LANE_W, default 32: lane width in bits, legal values 8..32.
REQ-003 SHALL have parameter ACC_W, default 64: accumulator and result width, with ACC_W >= 2*LANE_W.
REQ-004 SHALL have parameter SATURATE, default 0: 1 selects saturate on overflow, 0 selects wrap.
REQ-005 SHALL have clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have in_valid, input, 1 bit: beat present.
REQ-008 SHALL have in_ready, output, 1 bit: block accepts a beat.
REQ-009 SHALL have vec_a, input, LANES*LANE_W bits: operand A; lane i is vec_a[LANE_W*i +: LANE_W].
REQ-010 SHALL have vec_b, input, LANES*LANE_W bits: operand B; same lane packing as vec_a.
REQ-011 SHALL have in_last, input, 1 bit: marks the final beat of a vector.
REQ-012 SHALL have signed_mode, input, 1 bit: 1 = two's-complement lanes, 0 = unsigned lanes.
REQ-013 SHALL have out_valid, output, 1 bit: result present.
REQ-014 SHALL have out_ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have dot_result, output, ACC_W bits: accumulated dot product.
REQ-016 SHALL have overflow, output, 1 bit: the vector overflowed ACC_W.

Function
REQ-017 SHALL accept a beat on a rising edge only when in_valid and in_ready are both 1.
REQ-018 SHALL sample signed_mode on the first beat of a vector and hold it until that vector's result is consumed; later changes within the vector have no effect.
REQ-019 SHALL register all LANES products, each 2*LANE_W bits wide and sign- or zero-extended per mode, one cycle after acceptance (stage 1).
REQ-020 SHALL add the sum of the stage-1 products to the accumulator one cycle later (stage 2); the addition uses an internal width sufficient to be exact.
REQ-021 SHALL, when the exact accumulated value falls outside the ACC_W range (signed or unsigned per mode), set overflow to 1 and hold it as sticky until the result is consumed.
REQ-022 SHALL, on overflow with SATURATE=1, clamp the accumulator to the range limit: 0x7F..F or 0x80..0 when signed, 0xFF..F when unsigned; further beats of that vector keep it clamped in the overflow direction.
REQ-023 SHALL, on overflow with SATURATE=0, keep the low ACC_W bits of the exact sum (wrap).
REQ-024 SHALL use the FSM states IDLE, ACCUM and DONE; reset enters IDLE.
REQ-025 SHALL transition IDLE to ACCUM on acceptance of a beat with in_last=0.
REQ-026 SHALL transition IDLE or ACCUM to DONE on acceptance of a beat with in_last=1.
REQ-027 SHALL transition DONE to IDLE when out_valid and out_ready are both 1.
REQ-028 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in DONE.
REQ-029 SHALL assert out_valid exactly 2 cycles after the in_last beat is accepted, with dot_result final at that point.
REQ-030 SHALL hold out_valid, dot_result and overflow stable while out_valid=1 and out_ready=0.
REQ-031 SHALL, on result consumption, clear the accumulator and overflow so the next vector starts from 0; the first beat of the next vector may be accepted in the cycle after consumption.
REQ-032 SHALL accept beats on consecutive cycles with no bubbles in ACCUM.
REQ-033 SHALL keep the accumulator and stage registers unchanged during idle cycles (in_valid=0) within a vector.

Reset
REQ-034 SHALL, while rst=1, force the FSM to IDLE and drive out_valid=0, dot_result=0, overflow=0, with the accumulator and stage-1 registers at 0 and in_ready=0.
REQ-035 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-036 SHALL discard any in-flight beat or pending result when rst asserts mid-vector; no partial result appears after reset.

Verification
REQ-037 SHALL be covered by: signed, single beat, a={1,2,3,4}, b={5,6,7,8}, in_last=1 -> out_valid 2 cycles later, dot_result=70, overflow=0.
REQ-038 SHALL be covered by: two back-to-back beats, first as in REQ-037 (in_last=0), then a all 0xFFFFFFFF (-1), b all 2 -> dot_result=62.
REQ-039 SHALL be covered by: lane0 a=0xFFFFFFFF, b=2, other lanes 0 -> dot_result 0x1_FFFF_FFFE unsigned; 0xFFFF_FFFF_FFFF_FFFE signed.
REQ-040 SHALL be covered by: signed, all lanes 0x7FFFFFFF x 0x7FFFFFFF, last -> SATURATE=0 gives 0xFFFF_FFFC_0000_0004 with overflow=1; SATURATE=1 gives 0x7FFF_FFFF_FFFF_FFFF with overflow=1.
REQ-041 SHALL be covered by: out_ready held low for 5 cycles after out_valid -> result stable, in_ready=0, offered beats not accepted; the next vector starts from 0 after the handshake.
REQ-042 SHALL be covered by: rst pulsed after the first beat of a 3-beat vector -> all outputs 0, no out_valid; a new single-beat vector then yields only its own product sum.

Source files
------------

// File: rtl/vec_dot_accum.sv
// vec_dot_accum: streaming multi-lane dot product with a two-stage
// multiply / accumulate pipeline and optional saturation.
//
// Ports:
//   clk, rst                 - clock, async active-high reset
//   in_valid / in_ready      - beat handshake
//   vec_a, vec_b             - LANES packed operands, lane i at [LANE_W*i +: LANE_W]
//   in_last                  - final beat of the vector
//   signed_mode              - 1 = two's-complement lanes, sampled on first beat
//   out_valid / out_ready    - result handshake
//   dot_result               - accumulated dot product (ACC_W bits)
//   overflow                 - sticky: the vector left the ACC_W range
module vec_dot_accum #(
    parameter int LANES    = 4,
    parameter int LANE_W   = 32,
    parameter int ACC_W    = 64,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   vec_a,
    input  logic [LANES*LANE_W-1:0]   vec_b,
    input  logic                      in_last,
    input  logic                      signed_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          dot_result,
    output logic                      overflow
);

    localparam int PW = 2 * LANE_W;
    // Up to 16 products of PW <= ACC_W bits plus the accumulator and a
    // sign bit for unsigned mode fit exactly in ACC_W + 6 bits.
    localparam int EW = ACC_W + 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_accept;
    logic w_consume;
    logic w_mode;

    logic r_mode;

    logic [PW-1:0] w_prod    [LANES];
    logic [PW-1:0] r_s1_prod [LANES];
    logic          r_s1_valid;
    logic          r_s1_last;
    logic          r_s2_last;
    logic          r_out_valid;

    logic [EW-1:0] w_pext [LANES];
    logic [EW-1:0] w_sum;
    logic [EW-1:0] w_accx;
    logic [EW-1:0] w_exact;

    logic [EW-ACC_W:0]   w_hi_s;
    logic [EW-ACC_W-1:0] w_hi_u;
    logic                w_ovf;
    logic                w_set_sat;

    logic [ACC_W-1:0] w_max;
    logic [ACC_W-1:0] w_min;
    logic [ACC_W-1:0] w_acc_nxt;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_sat;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign in_ready  = ~rst & (r_state != S_DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_out_valid & out_ready;

    // The first beat of a vector uses the live mode pin; later beats use
    // the value latched on that first beat.
    assign w_mode = (r_state == S_IDLE) ? signed_mode : r_mode;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_consume) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
        end else if (w_accept && (r_state == S_IDLE)) begin
            r_mode <= signed_mode;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: lane products
    // ------------------------------------------------------------------
    // Operands are extended to PW bits per mode; the low PW bits of the
    // product of extended operands equal the exact signed/unsigned product.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [PW-1:0] ax;
            logic [PW-1:0] bx;
            ax = {{LANE_W{w_mode & vec_a[LANE_W*i+LANE_W-1]}},
                  vec_a[LANE_W*i +: LANE_W]};
            bx = {{LANE_W{w_mode & vec_b[LANE_W*i+LANE_W-1]}},
                  vec_b[LANE_W*i +: LANE_W]};
            w_prod[i] = ax * bx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_s1_prod[i] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept & in_last;
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_s1_prod[i] <= w_prod[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: exact sum, range check, wrap or clamp
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_pext[i] = {{(EW-PW){r_mode & r_s1_prod[i][PW-1]}},
                         r_s1_prod[i]};
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + w_pext[i];
        end
    end

    assign w_accx  = {{(EW-ACC_W){r_mode & r_acc[ACC_W-1]}}, r_acc};
    assign w_exact = w_accx + w_sum;

    // Signed: in range when bits [EW-1:ACC_W-1] are all copies of the sign.
    // Unsigned: in range when every bit above ACC_W-1 is zero.
    assign w_hi_s = w_exact[EW-1:ACC_W-1];
    assign w_hi_u = w_exact[EW-1:ACC_W];
    assign w_ovf  = r_mode ? ((w_hi_s != '0) && (w_hi_s != '1))
                           : (w_hi_u != '0);

    assign w_max = r_mode ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
    assign w_min = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        w_acc_nxt = w_exact[ACC_W-1:0];
        w_set_sat = 1'b0;
        if (SATURATE != 0) begin
            if (r_sat) begin
                // Once clamped, stay at the limit for the rest of the vector.
                w_acc_nxt = r_acc;
            end else if (w_ovf) begin
                w_set_sat = 1'b1;
                w_acc_nxt = (r_mode && w_exact[EW-1]) ? w_min : w_max;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_sat <= 1'b0;
        end else if (w_consume) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_sat <= 1'b0;
        end else if (r_s1_valid) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_ovf;
            r_sat <= r_sat | w_set_sat;
        end
    end

    // ------------------------------------------------------------------
    // Result valid: one cycle after the last beat's accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_s2_last <= r_s1_valid & r_s1_last;
            if (w_consume) begin
                r_out_valid <= 1'b0;
            end else if (r_s2_last) begin
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign dot_result = r_acc;
    assign overflow   = r_ovf;

endmodule
